csr_bridge: RTL and testbench



---
 rtl/csr_bridge_pkg.sv | 30 +++
 rtl/csr_bridge.sv | 141 ++++++++++++++
 tb/tb_csr_bridge.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bridge_pkg.sv
// Shared types and constants for the byte-stream CSR bridge and the CSR responders.
package csr_bridge_pkg;

  localparam logic [11:0] IDLE_ADDR = 12'h000;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_NORESP   = 8'h01;
  localparam logic [7:0] ST_RESERVED = 8'h02;

  localparam logic [2:0] MOD_NONE  = 3'b000;
  localparam logic [2:0] MOD_WRITE = 3'b001;
  localparam logic [2:0] MOD_SET   = 3'b010;
  localparam logic [2:0] MOD_CLEAR = 3'b011;

  typedef enum logic [2:0] {
    S_RX_OP, S_RX_AL, S_RX_AH, S_RX_DATA,
    S_BUS_ADDR, S_BUS_EXEC, S_BUS_CAPT, S_TX
  } state_e;

  // Opcode field maps straight onto the modify encoding.
  function automatic logic [2:0] op_to_mod(input logic [1:0] op);
    return {1'b0, op};
  endfunction

endpackage

// File: rtl/csr_bridge.sv
// Host byte-stream to CSR bus initiator: parse command, run one D/E/M access,
// return a 5-byte status + read-data response.
module csr_bridge
  import csr_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [11:0] csr_addr,
  output logic        csr_read,
  output logic [2:0]  csr_modify,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_valid,
  output logic        busy
);

  state_e          state_q;
  logic            in_ready_q, out_valid_q, read_q, busy_q, rsv_q;
  logic [7:0]      out_data_q;
  logic [11:0]     addr_q, tgt_q;
  logic [2:0]      modify_q, cnt_q;
  logic [31:0]     wdata_q;
  logic [1:0]      op_q;
  logic [3:0][7:0] wbuf_q, rdata_q;
  logic            in_acc, out_acc;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_RX_OP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= IDLE_ADDR;
      read_q      <= 1'b0;
      modify_q    <= MOD_NONE;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      op_q        <= OP_READ;
      rsv_q       <= 1'b0;
      tgt_q       <= '0;
      wbuf_q      <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_RX_OP: if (in_acc) begin
          op_q    <= in_data[1:0];
          rsv_q   <= |in_data[7:2];
          wbuf_q  <= '0;
          state_q <= S_RX_AL;
        end
        S_RX_AL: if (in_acc) begin
          tgt_q[7:0] <= in_data;
          state_q    <= S_RX_AH;
        end
        S_RX_AH: if (in_acc) begin
          tgt_q[11:8] <= in_data[3:0];
          cnt_q       <= '0;
          if (rsv_q) begin
            // Reserved opcode: skip the bus entirely and answer straight away.
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= ST_RESERVED;
            rdata_q     <= '0;
            state_q     <= S_TX;
          end else if (op_q != OP_READ) begin
            state_q <= S_RX_DATA;
          end else begin
            in_ready_q <= 1'b0;
            addr_q     <= {in_data[3:0], tgt_q[7:0]};
            busy_q     <= 1'b1;
            state_q    <= S_BUS_ADDR;
          end
        end
        S_RX_DATA: if (in_acc) begin
          wbuf_q[cnt_q[1:0]] <= in_data;
          cnt_q              <= cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            in_ready_q <= 1'b0;
            addr_q     <= tgt_q;
            busy_q     <= 1'b1;
            state_q    <= S_BUS_ADDR;
          end
        end
        S_BUS_ADDR: begin
          addr_q   <= IDLE_ADDR;
          read_q   <= 1'b1;
          modify_q <= op_to_mod(op_q);
          wdata_q  <= wbuf_q;
          state_q  <= S_BUS_EXEC;
        end
        S_BUS_EXEC: begin
          read_q   <= 1'b0;
          modify_q <= MOD_NONE;
          wdata_q  <= '0;
          state_q  <= S_BUS_CAPT;
        end
        S_BUS_CAPT: begin
          // Responders present M-stage data now; capture it with the status.
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= csr_valid ? ST_OK : ST_NORESP;
          rdata_q     <= csr_valid ? csr_rdata : '0;
          cnt_q       <= '0;
          state_q     <= S_TX;
        end
        S_TX: if (out_acc) begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd4) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= S_RX_OP;
          end else begin
            out_data_q <= rdata_q[cnt_q[1:0]];
          end
        end
        default: state_q <= S_RX_OP;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign csr_addr   = addr_q;
  assign csr_read   = read_q;
  assign csr_modify = modify_q;
  assign csr_wdata  = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_csr_bridge.sv
// Scoreboarded bench for csr_bridge with a small D/E/M CSR responder model.
module tb_csr_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid, out_ready;
  logic [7:0]  out_data;
  logic [11:0] csr_addr;
  logic        csr_read, csr_valid, busy;
  logic [2:0]  csr_modify;
  logic [31:0] csr_wdata, csr_rdata;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  bit stall_mode = 1'b0;

  logic [7:0]  exp_q[$];
  logic [11:0] addr_q[$];

  always #5 clk = ~clk;

  csr_bridge dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .csr_addr(csr_addr), .csr_read(csr_read), .csr_modify(csr_modify),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_valid(csr_valid),
    .busy(busy)
  );

  // Responders: VENDORID 0xF11 = 0, 0xF14 = 0, 4-pin LED at 0xBC1.
  logic [3:0]  led = 4'h0;
  logic        hit_led, hit_zero, m_valid;
  logic [31:0] m_rdata;
  always @(posedge clk) begin
    hit_led  <= (csr_addr == 12'hBC1);
    hit_zero <= (csr_addr == 12'hF11) || (csr_addr == 12'hF14);
    m_valid  <= 1'b0;
    m_rdata  <= 32'h0;
    if (rstn && csr_read) begin
      if (hit_led) begin
        m_valid <= 1'b1;
        m_rdata <= {28'h0, led};
        case (csr_modify)
          3'b001:  led <= csr_wdata[3:0];
          3'b010:  led <= led | csr_wdata[3:0];
          3'b011:  led <= led & ~csr_wdata[3:0];
          default: led <= led;
        endcase
      end else if (hit_zero) begin
        m_valid <= 1'b1;
      end
    end
  end
  assign csr_rdata = m_rdata;
  assign csr_valid = m_valid;

  // Response monitor: pops expected bytes on each transfer, checks hold under stall.
  initial begin
    logic       held;
    logic [7:0] held_data, e;
    held = 1'b0;
    held_data = 8'h00;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (!(out_valid && out_data == held_data)) begin
          errors++;
          $display("FAIL hold: got v=%0b d=%02h want v=1 d=%02h", out_valid, out_data, held_data);
        end
      end
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_extra: got %02h want no byte", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL resp_byte: got %02h want %02h", out_data, e);
          end
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  // Bus monitor: one-cycle read pulse, preceded by the target address cycle.
  initial begin
    logic [11:0] prev_addr, ea;
    logic        prev_read;
    prev_addr = 12'h000;
    prev_read = 1'b0;
    forever begin
      @(negedge clk);
      if (csr_read) begin
        pulses++;
        checks++;
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 12'hFFF;
        if (prev_read || prev_addr !== ea || csr_addr !== 12'h000) begin
          errors++;
          $display("FAIL bus_pulse: got prev_addr=%03h prev_read=%0b addr=%03h want prev_addr=%03h prev_read=0 addr=000",
                   prev_addr, prev_read, csr_addr, ea);
        end
      end
      prev_addr = csr_addr;
      prev_read = csr_read;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall);
    int guard;
    if (stall > 0) repeat ($urandom_range(0, stall)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [7:0] st, input logic [31:0] rd, input int stall);
    exp_q.push_back(st);
    for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    if (op[7:2] == 6'd0) begin
      addr_q.push_back(addr);
      exp_pulses++;
    end
    send_byte(op, stall);
    send_byte(addr[7:0], stall);
    send_byte({4'hA, addr[11:8]}, stall);  // upper nibble must be ignored
    if (op[7:2] == 6'd0 && op[1:0] != 2'b00)
      for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8], stall);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes pending want 0", name, exp_q.size());
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL %s_pulses: got %0d want %0d", name, pulses, exp_pulses);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({in_ready, out_valid, out_data, csr_addr, csr_read, csr_modify, csr_wdata, busy} !==
        {1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 3'b000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got rdy=%0b ov=%0b od=%02h addr=%03h rd=%0b mod=%0d wd=%08h busy=%0b want rdy=1 all others 0",
               name, in_ready, out_valid, out_data, csr_addr, csr_read, csr_modify, csr_wdata, busy);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rstn = 1'b1;

    cmd(8'h00, 12'hF11, 32'h0, 8'h00, 32'h0, 0);
    drain("read_vendorid");

    cmd(8'h01, 12'hBC1, 32'h0000000A, 8'h00, 32'h0, 0);
    cmd(8'h00, 12'hBC1, 32'h0, 8'h00, 32'h0000000A, 0);
    cmd(8'h02, 12'hBC1, 32'h00000005, 8'h00, 32'h0000000A, 0);
    cmd(8'h03, 12'hBC1, 32'h00000008, 8'h00, 32'h0000000F, 0);
    cmd(8'h00, 12'hBC1, 32'h0, 8'h00, 32'h00000007, 0);
    drain("led_modify");

    cmd(8'h00, 12'h123, 32'h0, 8'h01, 32'h0, 0);
    cmd(8'h84, 12'h123, 32'h0, 8'h02, 32'h0, 0);
    drain("noresp_reserved");

    stall_mode = 1'b1;
    cmd(8'h01, 12'hBC1, 32'hFFFF_FFF3, 8'h00, 32'h00000007, 2);
    cmd(8'h00, 12'hBC1, 32'h0, 8'h00, 32'h00000003, 2);
    cmd(8'h00, 12'hF11, 32'h0, 8'h00, 32'h0, 2);
    cmd(8'h00, 12'h123, 32'h0, 8'h01, 32'h0, 2);
    cmd(8'hFF, 12'hBC1, 32'h0, 8'h02, 32'h0, 2);
    cmd(8'h03, 12'hBC1, 32'h00000001, 8'h00, 32'h00000003, 2);
    cmd(8'h00, 12'hBC1, 32'h0, 8'h00, 32'h00000002, 2);
    drain("stalled_b2b");
    stall_mode = 1'b0;

    // Abandon a frame after ADDR_LO with a one-cycle reset.
    send_byte(8'h00, 0);
    send_byte(8'h14, 0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_idle("mid_frame_reset");
    rstn = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    cmd(8'h00, 12'hF14, 32'h0, 8'h00, 32'h0, 0);
    drain("post_reset_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
